libv_base_smult_pipe: RTL and testbench
=======================================

Name: libv_base_smult_pipe

Overview:
- Multi-lane, pipelined signed fractional multiplier with a valid/ready handshake on both sides.
- Successor to the single-lane saturating multiply primitive. Adds:
  - LANES parallel channels
  - configurable pipeline depth with full backpressure
  - truncate or round-half-up output modes
  - per-lane overflow flags plus a sticky overflow status
- Used in DMA datapath scaling and gain stages between stream buffers.

Parameters:
- LANES, 4, number of independent multiplier lanes sharing one handshake.
- WIA, 8, signed width of each lane's operand A.
- WIB, 8, signed width of each lane's operand B.
- WO, 8, signed output width; legal range 1..WIA+WIB-1.
- LAT, 2, pipeline stages; legal range >=1.
- RND, 0, 0 = truncate (floor), 1 = round half up with saturation.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- a  input  LANES*WIA  packed operands A; lane i at [i*WIA +: WIA].
- b  input  LANES*WIB  packed operands B; lane i at [i*WIB +: WIB].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- o  output  LANES*WO  packed results; lane i at [i*WO +: WO].
- ovf  output  LANES  per-lane overflow or saturation for the current output beat.
- ovf_sticky  output  1  set when any accepted output beat had any ovf bit set.
- ovf_clr  input  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset:
  - Asynchronous on rst_n low; all stage valid bits clear.
  - out_valid=0, o=0, ovf=0, ovf_sticky=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight beats; nothing is replayed.
- Per-lane arithmetic, N = WIA+WIB:
  - P = signed(a_i)*signed(b_i), N bits.
  - If P[N-1] != P[N-2] (only for min*min), limit P to an N-1-bit value: positive max, 0 then all ones; set ovf_i.
  - Otherwise take P[N-2:0].
  - Let L be the N-1-bit limited value and D = N-1-WO the number of discarded bits.
  - RND=0: result = L[N-2:D].
  - RND=1 and D>0: result = L[N-2:D] + L[D-1].
    - If the sum exceeds 2^(WO-1)-1, saturate to 2^(WO-1)-1 and set ovf_i.
    - Negative results cannot overflow.
  - D=0: rounding is a no-op.
- Pipeline:
  - LAT register stages, each holding a valid bit, per-lane data and per-lane ovf.
  - The multiply may be split across stages freely; results appear exactly LAT cycles after acceptance when there is no stall.
  - A stage loads when its successor is empty or advancing: ready_k = !valid_k | ready_(k+1); the last stage uses out_ready.
  - in_ready = ready_1, combinational from stage state and out_ready.
  - Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
  - Sustains one beat per cycle when out_ready is held high.
  - Under stall (out_valid=1, out_ready=0): o, ovf and out_valid hold stable; no beat is lost or duplicated.
  - Beats leave in acceptance order.
  - Data of an invalid stage is don't-care, but o must not change while out_valid=1 and out_ready=0.
- Sticky overflow:
  - ovf_sticky sets on an output transfer with |ovf.
  - ovf_clr clears it.
  - Set and clear in the same cycle: set wins.
- All lanes share valid/ready; lanes never advance independently.

Test Plan:
All scenarios use LANES=4, WIA=WIB=WO=8, LAT=2.
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, o=0, ovf=0, ovf_sticky=0; release -> in_ready=1, first result 2 cycles after the first accepted beat.
- Truncate (RND=0), lanes (64,64), (-128,-128), (-8,8), (3,22):
  - o lanes = 0x20, 0x7F, 0xFF, 0x00.
  - ovf = 4'b0010; ovf_sticky=1 after the output transfer.
- Round (RND=1), same inputs:
  - o = 0x20, 0x7F, 0x00, 0x01.
  - ovf = 4'b0010. For lane 1, rounding 0x7F+1 saturates to 0x7F.
- Throughput, out_ready=1: 100 back-to-back random beats -> 100 outputs in order, matching the golden model, with no bubble after the initial latency of 2.
- Backpressure: random out_ready toggling at 50% and random in_valid -> no loss or duplication, o stable during every stall, in_ready=0 only when both stages are full and out_ready=0.
- Sticky clear:
  - ovf_clr pulsed in the same cycle as an output transfer carrying ovf!=0 -> ovf_sticky stays 1.
  - ovf_clr pulsed alone next cycle -> ovf_sticky=0.
  - Async reset asserted with 2 beats in flight -> both dropped, out_valid=0 immediately.

Source files
------------

// File: rtl/libv_base_smult_pipe.sv
// Multi-lane pipelined signed fractional multiplier with valid/ready on both sides.
// Each lane saturates min*min, then truncates or rounds half up to WO bits.
module libv_base_smult_pipe #(
   parameter int LANES = 4,
   parameter int WIA   = 8,
   parameter int WIB   = 8,
   parameter int WO    = 8,
   parameter int LAT   = 2,
   parameter int RND   = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIA-1:0]   a,
   input  logic [LANES*WIB-1:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WO-1:0]    o,
   output logic [LANES-1:0]       ovf,
   output logic                   ovf_sticky,
   input  logic                   ovf_clr
);

   localparam int N = WIA + WIB;
   localparam int D = N - 1 - WO;
   localparam logic [WO-1:0]  P_MAX = {WO{1'b1}} >> 1;
   localparam logic [N-2:0]   L_MAX = {(N-1){1'b1}} >> 1;

   logic [LANES*WO-1:0] w_res;
   logic [LANES-1:0]    w_res_ovf;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic signed [N-1:0] w_a_ext;
      logic signed [N-1:0] w_b_ext;
      logic signed [N-1:0] w_p;
      logic                w_lim_ovf;
      logic [N-2:0]        w_lim;
      logic [WO-1:0]       w_trunc;
      logic                w_unused_lsbs;

      assign w_a_ext   = N'($signed(a[i*WIA +: WIA]));
      assign w_b_ext   = N'($signed(b[i*WIB +: WIB]));
      assign w_p       = w_a_ext * w_b_ext;
      // Only min*min can disagree in the top two bits.
      assign w_lim_ovf = w_p[N-1] ^ w_p[N-2];
      assign w_lim     = w_lim_ovf ? L_MAX : w_p[N-2:0];
      assign w_trunc   = w_lim[N-2 -: WO];
      assign w_unused_lsbs = ^w_lim;

      if (RND != 0 && D > 0) begin : g_rnd
         logic w_half;
         logic w_sat;
         assign w_half = w_lim[D-1];
         // Rounding up can only overflow from the positive maximum.
         assign w_sat  = w_half && (w_trunc == P_MAX);
         assign w_res[i*WO +: WO] = w_sat ? P_MAX : w_trunc + WO'(w_half);
         assign w_res_ovf[i]      = w_lim_ovf | w_sat;
      end else begin : g_trunc
         assign w_res[i*WO +: WO] = w_trunc;
         assign w_res_ovf[i]      = w_lim_ovf;
      end
   end

   logic [LAT-1:0]                 w_vld;
   logic [LAT-1:0][LANES*WO-1:0]   w_data;
   logic [LAT-1:0][LANES-1:0]      w_ovf;
   logic [LAT-1:0]                 w_rdy;

   for (genvar k = 0; k < LAT; k++) begin : g_stage
      logic                r_vld;
      logic [LANES*WO-1:0] r_data;
      logic [LANES-1:0]    r_ovf;
      logic                w_prev_vld;
      logic [LANES*WO-1:0] w_prev_data;
      logic [LANES-1:0]    w_prev_ovf;

      if (k == 0) begin : g_first
         assign w_prev_vld  = in_valid;
         assign w_prev_data = w_res;
         assign w_prev_ovf  = w_res_ovf;
      end else begin : g_next
         assign w_prev_vld  = w_vld[k-1];
         assign w_prev_data = w_data[k-1];
         assign w_prev_ovf  = w_ovf[k-1];
      end

      // A stage can load if it or any stage after it has a hole, or the tail drains.
      assign w_rdy[k]  = out_ready | ~(&w_vld[LAT-1:k]);
      assign w_vld[k]  = r_vld;
      assign w_data[k] = r_data;
      assign w_ovf[k]  = r_ovf;

      // NOTE: data registers are reset as well, because o and ovf must read 0 out of reset.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_ovf  <= '0;
         end else if (w_rdy[k]) begin
            // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
            r_vld <= w_prev_vld;
            if (w_prev_vld) begin
               r_data <= w_prev_data;
               r_ovf  <= w_prev_ovf;
            end
         end
      end
   end

   logic r_sticky;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
      end else if (out_valid && out_ready && (|ovf)) begin
         r_sticky <= 1'b1;
      end else if (ovf_clr) begin
         r_sticky <= 1'b0;
      end
   end

   assign in_ready   = w_rdy[0];
   assign out_valid  = w_vld[LAT-1];
   assign o          = w_data[LAT-1];
   assign ovf        = w_ovf[LAT-1];
   assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_libv_base_smult_pipe.sv
// Directed bench for libv_base_smult_pipe: a truncating and a rounding instance share stimulus
// and are scored against an integer reference model and a two-stage occupancy model.
module tb_libv_base_smult_pipe;

   localparam logic [31:0] VA = 32'h03F88040;   // lanes: 64, -128, -8, 3
   localparam logic [31:0] VB = 32'h16088040;   // lanes: 64, -128,  8, 22

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic        ovf_clr;
   logic [31:0] a;
   logic [31:0] b;

   logic        in_ready_t, out_valid_t, ovf_sticky_t;
   logic [31:0] o_t;
   logic [3:0]  ovf_t;
   logic        in_ready_r, out_valid_r, ovf_sticky_r;
   logic [31:0] o_r;
   logic [3:0]  ovf_r;

   int n_checks = 0;
   int n_fail   = 0;
   int n_out    = 0;

   logic [63:0] sb [$];
   bit          v0, v1, stalled, stk_t, stk_r;
   logic [31:0] last_o_t;
   logic [3:0]  last_ovf_t;

   always #5 clk = ~clk;

   libv_base_smult_pipe #(.LANES(4), .WIA(8), .WIB(8), .WO(8), .LAT(2), .RND(0)) u_trn (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
      .a(a), .b(b), .out_valid(out_valid_t), .out_ready(out_ready),
      .o(o_t), .ovf(ovf_t), .ovf_sticky(ovf_sticky_t), .ovf_clr(ovf_clr)
   );

   libv_base_smult_pipe #(.LANES(4), .WIA(8), .WIB(8), .WO(8), .LAT(2), .RND(1)) u_rnd (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
      .a(a), .b(b), .out_valid(out_valid_r), .out_ready(out_ready),
      .o(o_r), .ovf(ovf_r), .ovf_sticky(ovf_sticky_r), .ovf_clr(ovf_clr)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: full-precision integer product, scaled by 2^-7 with floor or round-half-up.
   function automatic void model(input logic [31:0] av, input logic [31:0] bv, input bit rnd,
                                 output logic [31:0] ov, output logic [3:0] fv);
      ov = '0;
      fv = '0;
      for (int i = 0; i < 4; i++) begin
         int p;
         int r;
         bit f;
         p = int'($signed(av[i*8 +: 8])) * int'($signed(bv[i*8 +: 8]));
         f = 1'b0;
         if (p > 16383) begin
            p = 16383;
            f = 1'b1;
         end
         r = rnd ? ((p + 64) >>> 7) : (p >>> 7);
         if (r > 127) begin
            r = 127;
            f = 1'b1;
         end
         ov[i*8 +: 8] = r[7:0];
         fv[i]        = f;
      end
   endfunction

   task automatic reset_model();
      sb.delete();
      v0      = 1'b0;
      v1      = 1'b0;
      stalled = 1'b0;
      stk_t   = 1'b0;
      stk_r   = 1'b0;
   endtask

   // One clock cycle: called just after a falling edge, returns just after the next one.
   task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ordy, input logic clr);
      logic [31:0] eo_t, eo_r;
      logic [3:0]  ef_t, ef_r;
      logic [63:0] head;
      bit          w0, w1, xin, xout;
      in_valid  = iv;
      a         = ia;
      b         = ib;
      out_ready = ordy;
      ovf_clr   = clr;
      #1;
      w1 = !v1 || ordy;
      w0 = !v0 || w1;
      check("in_ready_trn", 64'(in_ready_t), 64'(w0));
      check("in_ready_rnd", 64'(in_ready_r), 64'(w0));
      check("out_valid_trn", 64'(out_valid_t), 64'(v1));
      check("out_valid_rnd", 64'(out_valid_r), 64'(v1));
      check("sticky_trn", 64'(ovf_sticky_t), 64'(stk_t));
      check("sticky_rnd", 64'(ovf_sticky_r), 64'(stk_r));
      if (stalled) begin
         check("stall_o", 64'(o_t), 64'(last_o_t));
         check("stall_ovf", 64'(ovf_t), 64'(last_ovf_t));
      end
      ef_t = '0;
      ef_r = '0;
      if (v1 && sb.size() > 0) begin
         head = sb[0];
         model(head[63:32], head[31:0], 1'b0, eo_t, ef_t);
         model(head[63:32], head[31:0], 1'b1, eo_r, ef_r);
         check("o_trn", 64'(o_t), 64'(eo_t));
         check("ovf_trn", 64'(ovf_t), 64'(ef_t));
         check("o_rnd", 64'(o_r), 64'(eo_r));
         check("ovf_rnd", 64'(ovf_r), 64'(ef_r));
      end
      xin  = iv && w0;
      xout = v1 && ordy;
      if (xout && (|ef_t)) stk_t = 1'b1;
      else if (clr)        stk_t = 1'b0;
      if (xout && (|ef_r)) stk_r = 1'b1;
      else if (clr)        stk_r = 1'b0;
      if (xout) begin
         void'(sb.pop_front());
         n_out++;
      end
      if (xin) sb.push_back({ia, ib});
      stalled    = v1 && !ordy;
      last_o_t   = o_t;
      last_ovf_t = ovf_t;
      if (w1) v1 = v0;
      if (w0) v0 = iv;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      a         = VA;
      b         = VB;
      out_ready = 1'b1;
      ovf_clr   = 1'b0;
      reset_model();

      // Reset held with in_valid high: everything stays clear.
      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(out_valid_t), 64'd0);
      check("rst_o", 64'(o_t), 64'd0);
      check("rst_ovf", 64'(ovf_t), 64'd0);
      check("rst_sticky", 64'(ovf_sticky_t), 64'd0);
      check("rst_o_rnd", 64'(o_r), 64'd0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready_t), 64'd1);

      // Directed vector through both modes; result two cycles after acceptance.
      step(1'b1, VA, VB, 1'b1, 1'b0);
      check("lat1_valid", 64'(out_valid_t), 64'd0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("lat2_valid", 64'(out_valid_t), 64'd1);
      check("dir_o_trn", 64'(o_t), 64'h00FF7F20);
      check("dir_ovf_trn", 64'(ovf_t), 64'b0010);
      check("dir_o_rnd", 64'(o_r), 64'h01007F20);
      check("dir_ovf_rnd", 64'(ovf_r), 64'b0010);
      check("dir_sticky_before", 64'(ovf_sticky_t), 64'd0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("dir_sticky_after_trn", 64'(ovf_sticky_t), 64'd1);
      check("dir_sticky_after_rnd", 64'(ovf_sticky_r), 64'd1);
      check("dir_drained", 64'(out_valid_t), 64'd0);

      // Back-to-back beats with out_ready high: 100 outputs in exactly 102 cycles.
      n_out = 0;
      for (int i = 0; i < 100; i++) step(1'b1, $urandom, $urandom, 1'b1, 1'b0);
      repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("thru_count", 64'(n_out), 64'd100);
      check("thru_empty", 64'(sb.size()), 64'd0);

      // Random in_valid and out_ready; the step model checks order, stalls and in_ready.
      n_out = 0;
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), (i % 37 == 0) ? 32'h80808080 : $urandom,
              (i % 37 == 0) ? 32'h80808080 : $urandom, 1'($urandom_range(0, 1)), 1'b0);
      end
      repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("bp_empty", 64'(sb.size()), 64'd0);
      check("bp_some_out", 64'(n_out > 50), 64'd1);

      // Sticky: set wins over a simultaneous clear; a lone clear then drops it.
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      check("clr_pre", 64'(ovf_sticky_t), 64'd0);
      step(1'b1, 32'h00000080, 32'h00000080, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("clr_ovf_beat", 64'(ovf_t), 64'b0001);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      check("clr_set_wins_trn", 64'(ovf_sticky_t), 64'd1);
      check("clr_set_wins_rnd", 64'(ovf_sticky_r), 64'd1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      check("clr_alone", 64'(ovf_sticky_t), 64'd0);

      // Async reset with both stages full: beats dropped, out_valid low immediately.
      step(1'b1, VA, VB, 1'b0, 1'b0);
      step(1'b1, 32'h01010101, 32'h02020202, 1'b0, 1'b0);
      check("full_valid", 64'(out_valid_t), 64'd1);
      check("full_in_ready", 64'(in_ready_t), 64'd0);
      #3 rst_n = 1'b0;
      #1;
      check("async_valid_trn", 64'(out_valid_t), 64'd0);
      check("async_valid_rnd", 64'(out_valid_r), 64'd0);
      check("async_o", 64'(o_t), 64'd0);
      reset_model();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("no_replay", 64'(out_valid_t), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
